// File: rtl/minbd_arb_stage.sv
// MinBD 2x2 deflection arbitration stage: golden marking, rank/LFSR arbitration, registered steering.
// Optional deflection counter compiled in when MINBD_ARB_DEFL_CNT_EN is defined.
module minbd_arb_stage #(
  parameter int          DEST_W     = 3,
  parameter int          PAY_W      = 6,
  parameter int          TAG_W      = 2,
  parameter int          LOCAL_DEST = 0,
  parameter int          EPOCH      = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DEST_W+PAY_W+1:0]   in0,
  input  logic [DEST_W+PAY_W+1:0]   in1,
  input  logic                      defl_clr,
  output logic [DEST_W+PAY_W+1:0]   out0,
  output logic [DEST_W+PAY_W+1:0]   out1,
  output logic [TAG_W-1:0]          golden_tag,
  output logic [CNT_W-1:0]          defl_cnt
);

  localparam int FLIT_W = DEST_W + PAY_W + 2;
  localparam int GB     = FLIT_W - 1;
  localparam int VB     = FLIT_W - 2;
  localparam int EP_W   = (EPOCH > 1) ? $clog2(EPOCH) : 1;
  localparam logic [15:0]       SEED    = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [DEST_W-1:0] LOCAL   = DEST_W'(LOCAL_DEST);
  localparam logic [EP_W-1:0]   EP_LAST = EP_W'(EPOCH - 1);

  logic [FLIT_W-1:0] out0_r, out1_r;
  logic [15:0]       lfsr_r;
  logic [EP_W-1:0]   epoch_r;
  logic [TAG_W-1:0]  golden_tag_r;

  logic [FLIT_W-1:0] f0_s, f1_s, win_s, lose_s, nxt_out0_s, nxt_out1_s;
  logic [1:0]        rank0_s, rank1_s;
  logic              sel1_s, win_far_s, lose_far_s, defl_s;
  logic [15:0]       lfsr_nxt_s;

  function automatic logic [FLIT_W-1:0] mark_flit(input logic [FLIT_W-1:0] f,
                                                  input logic [TAG_W-1:0]  tag);
    mark_flit = f;
    if (f[VB] && (f[TAG_W-1:0] == tag)) begin
      mark_flit[GB] = 1'b1;
    end else begin
      mark_flit[GB] = f[GB];
    end
  endfunction

  // A golden bit on an invalid flit carries no weight.
  function automatic logic [1:0] flit_rank(input logic [FLIT_W-1:0] f);
    if (!f[VB]) begin
      flit_rank = 2'd0;
    end else if (f[GB]) begin
      flit_rank = 2'd2;
    end else begin
      flit_rank = 2'd1;
    end
  endfunction

  // Marking, ranking, winner selection and port steering for the current pair.
  always_comb begin
    f0_s    = mark_flit(in0, golden_tag_r);
    f1_s    = mark_flit(in1, golden_tag_r);
    rank0_s = flit_rank(f0_s);
    rank1_s = flit_rank(f1_s);
    sel1_s  = 1'b0;
    if (rank1_s > rank0_s) begin
      sel1_s = 1'b1;
    end else if (rank1_s == rank0_s) begin
      sel1_s = lfsr_r[0];
    end else begin
      sel1_s = 1'b0;
    end
    win_s      = sel1_s ? f1_s : f0_s;
    lose_s     = sel1_s ? f0_s : f1_s;
    win_far_s  = (win_s[PAY_W +: DEST_W] != LOCAL);
    lose_far_s = (lose_s[PAY_W +: DEST_W] != LOCAL);
    if (win_far_s) begin
      nxt_out0_s = lose_s;
      nxt_out1_s = win_s;
    end else begin
      nxt_out0_s = win_s;
      nxt_out1_s = lose_s;
    end
    // The loser always gets the port opposite the winner's choice.
    defl_s     = lose_s[VB] && (lose_far_s == win_far_s);
    lfsr_nxt_s = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
  end

  // Output registers, tie-break LFSR and golden epoch/tag tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_r       <= {FLIT_W{1'b0}};
      out1_r       <= {FLIT_W{1'b0}};
      lfsr_r       <= SEED;
      epoch_r      <= {EP_W{1'b0}};
      golden_tag_r <= {TAG_W{1'b0}};
    end else begin
      out0_r <= nxt_out0_s;
      out1_r <= nxt_out1_s;
      lfsr_r <= lfsr_nxt_s;
      if (epoch_r == EP_LAST) begin
        epoch_r      <= {EP_W{1'b0}};
        golden_tag_r <= golden_tag_r + 1'b1;
      end else begin
        epoch_r      <= epoch_r + 1'b1;
        golden_tag_r <= golden_tag_r;
      end
    end
  end

  assign out0       = out0_r;
  assign out1       = out1_r;
  assign golden_tag = golden_tag_r;

`ifdef MINBD_ARB_DEFL_CNT_EN
  logic [CNT_W-1:0] defl_cnt_r;

  // Saturating deflection count; a clear wins over a same-cycle deflection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      defl_cnt_r <= {CNT_W{1'b0}};
    end else if (defl_clr) begin
      defl_cnt_r <= {CNT_W{1'b0}};
    end else if (defl_s && (defl_cnt_r != {CNT_W{1'b1}})) begin
      defl_cnt_r <= defl_cnt_r + 1'b1;
    end else begin
      defl_cnt_r <= defl_cnt_r;
    end
  end

  assign defl_cnt = defl_cnt_r;
`else
  logic unused_defl_s;
  assign unused_defl_s = defl_clr ^ defl_s;
  assign defl_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_minbd_arb_stage.sv
// Randomized self-checking bench for minbd_arb_stage against a rule-level reference model.
module tb_minbd_arb_stage;

  localparam int EPOCH = 4;
`ifdef MINBD_ARB_DEFL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] o0;
    logic [10:0] o1;
    logic        defl;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] in0_d = 11'h000, in1_d = 11'h000;
  logic        clr_d = 1'b0;
  logic [10:0] out0, out1;
  logic [1:0]  golden_tag;
  logic [3:0]  defl_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model state
  int          m_n = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [10:0] exp_out0 = 11'h000, exp_out1 = 11'h000;
  logic [1:0]  exp_tag = 2'd0;
  logic [3:0]  exp_cnt = 4'd0;
  res_t        cur_r;

  minbd_arb_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in0(in0_d), .in1(in1_d), .defl_clr(clr_d),
    .out0(out0), .out1(out1), .golden_tag(golden_tag), .defl_cnt(defl_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Spec rules: mark, rank, pick winner, place winner on its preferred port.
  function automatic res_t arb_ref(input logic [10:0] a, input logic [10:0] b,
                                   input int tag, input int tiebit);
    logic [10:0] f[2];
    logic [10:0] port[2];
    int rank[2];
    int w, l, pw, pl;
    res_t r;
    f[0] = a; f[1] = b;
    for (int i = 0; i < 2; i++) begin
      if (f[i][9] && (f[i][1:0] == 2'(tag))) f[i][10] = 1'b1;
      rank[i] = !f[i][9] ? 0 : (f[i][10] ? 2 : 1);
    end
    if (rank[0] > rank[1]) w = 0;
    else if (rank[1] > rank[0]) w = 1;
    else w = tiebit;
    l  = 1 - w;
    pw = (f[w][8:6] == 3'd0) ? 0 : 1;
    pl = (f[l][8:6] == 3'd0) ? 0 : 1;
    port[pw]     = f[w];
    port[1 - pw] = f[l];
    r.o0   = port[0];
    r.o1   = port[1];
    r.defl = f[l][9] && (pl != 1 - pw);
    return r;
  endfunction

  function automatic logic [10:0] mk(input logic g, input logic v,
                                     input logic [2:0] d, input logic [5:0] p);
    return {g, v, d, p};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic cyc(input logic [10:0] a, input logic [10:0] b, input logic c);
    in0_d = a; in1_d = b; clr_d = c;
    @(posedge clk);
    #1;
  endtask

  always_comb cur_r = arb_ref(in0_d, in1_d, (m_n / EPOCH) % 4, int'(m_lfsr[0]));

  // Reference model: advances one arbitration per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n      <= 0;
      m_lfsr   <= 16'hACE1;
      exp_out0 <= 11'h000;
      exp_out1 <= 11'h000;
      exp_tag  <= 2'd0;
      exp_cnt  <= 4'd0;
    end else begin
      exp_out0 <= cur_r.o0;
      exp_out1 <= cur_r.o1;
      exp_tag  <= 2'(((m_n + 1) / EPOCH) % 4);
      m_n      <= m_n + 1;
      m_lfsr   <= lfsr_adv(m_lfsr);
      if (!CNT_ON || clr_d) exp_cnt <= 4'd0;
      else if (cur_r.defl && exp_cnt != 4'd15) exp_cnt <= exp_cnt + 4'd1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out0", 32'(out0), 32'(exp_out0));
      chk("out1", 32'(out1), 32'(exp_out1));
      chk("golden_tag", 32'(golden_tag), 32'(exp_tag));
      chk("defl_cnt", 32'(defl_cnt), 32'(exp_cnt));
    end
  end

  initial begin
    int na, nb;
    logic [1:0] t;
    logic [10:0] a, b;
    na = 0; nb = 0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) cyc(11'($urandom), 11'($urandom), 1'($urandom));
    chk("rst_out0", 32'(out0), 32'h0);
    chk("rst_out1", 32'(out1), 32'h0);
    chk("rst_tag", 32'(golden_tag), 32'h0);
    chk("rst_cnt", 32'(defl_cnt), 32'h0);
    rst_n = 1'b1;

    cyc(11'h205, 11'h283, 1'b0);
    chk("first_out0", 32'(out0), 32'h205);
    chk("first_out1", 32'(out1), 32'h283);
    repeat (3) cyc(11'h000, 11'h000, 1'b0);
    chk("tag_after_4", 32'(golden_tag), 32'h1);

    cyc(11'h245, 11'h640, 1'b0);
    chk("contend_set", 32'((out0 == 11'h645 && out1 == 11'h640) ||
                           (out0 == 11'h640 && out1 == 11'h645)), 32'h1);
    chk("contend_cnt", 32'(defl_cnt), CNT_ON ? 32'h1 : 32'h0);
    repeat (7) cyc(11'h000, 11'h000, 1'b0);
    chk("tag_after_12", 32'(golden_tag), 32'h3);
    repeat (4) cyc(11'h000, 11'h000, 1'b0);
    chk("tag_wrap_16", 32'(golden_tag), 32'h0);

    cyc(11'h204, 11'h283, 1'b0);
    chk("mark_out0", 32'(out0), 32'h604);
    chk("mark_out1", 32'(out1), 32'h283);
    chk("mark_cnt", 32'(defl_cnt), CNT_ON ? 32'h1 : 32'h0);
    cyc(11'h004, 11'h283, 1'b0);
    chk("invalid_unmarked", 32'(out0), 32'h004);

    cyc(11'h201, 11'h202, 1'b1);
    chk("clr_priority", 32'(defl_cnt), 32'h0);
    for (int i = 0; i < 20; i++) begin
      t = 2'(((m_n / EPOCH) + 1) % 4);
      cyc(mk(1'b0, 1'b1, 3'd0, {4'(i), t}), mk(1'b0, 1'b1, 3'd0, {4'(i + 1), t}), 1'b0);
    end
    chk("saturate", 32'(defl_cnt), CNT_ON ? 32'd15 : 32'd0);

    for (int i = 0; i < 1000; i++) begin
      t = 2'(((m_n / EPOCH) + 1) % 4);
      a = mk(1'b0, 1'b1, 3'd0, {4'h5, t});
      b = mk(1'b0, 1'b1, 3'd0, {4'hA, t});
      cyc(a, b, 1'b0);
      if (out0 == a) na++;
      else if (out0 == b) nb++;
    end
    chk("both_orders", 32'(na > 0 && nb > 0), 32'h1);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out0", 32'(out0), 32'h0);
        chk("midrst_out1", 32'(out1), 32'h0);
        chk("midrst_tag", 32'(golden_tag), 32'h0);
        chk("midrst_cnt", 32'(defl_cnt), 32'h0);
        rst_n = 1'b1;
      end
      cyc(11'($urandom), 11'($urandom), ($urandom_range(15) == 0));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
